// File: rtl/prio_event_arbiter.sv
// Sticky event arbiter: captures request pulses, grants one line at a time on a valid/ready port.
// Define PRIO_EVENT_ARBITER_RR_EN for round-robin search instead of fixed highest-index-wins.
module prio_event_arbiter #(
  parameter int WIDTH = 64,
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  req,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDXW-1:0]   out_index,
  output logic [WIDTH-1:0]  pending
);

  logic [WIDTH-1:0] r_pend;
  logic             r_valid;
  logic [IDXW-1:0]  r_index;

  logic [WIDTH-1:0] w_cand;
  logic [WIDTH-1:0] w_win_mask;
  logic [IDXW-1:0]  w_winner;
  logic             w_load;

  // Same-cycle bypass so a fresh request can be granted on the next edge.
  assign w_cand = r_pend | req;

`ifdef PRIO_EVENT_ARBITER_RR_EN
  logic [IDXW-1:0] r_rr_ptr;

  // Index reached d steps below ptr, wrapping modulo WIDTH.
  function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] ptr, input int d);
    int t;
    t = int'(ptr) + WIDTH - d;
    if (t >= WIDTH) t = t - WIDTH;
    return IDXW'(t);
  endfunction

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_winner = '0;
    for (int d = WIDTH; d >= 1; d--) begin
      if (w_cand[rr_idx(r_rr_ptr, d)]) w_winner = rr_idx(r_rr_ptr, d);
    end
  end
`else
  always_comb begin
    w_winner = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_cand[i]) w_winner = IDXW'(i);
    end
  end
`endif

  assign w_win_mask = WIDTH'(1) << w_winner;
  assign w_load     = (~r_valid | out_ready) & (|w_cand) & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
    end else if (flush) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_pend  <= w_cand & ~w_win_mask;
      r_valid <= 1'b1;
      r_index <= w_winner;
    end else begin
      r_pend <= w_cand;
      if (r_valid && out_ready) r_valid <= 1'b0;
    end
  end

`ifdef PRIO_EVENT_ARBITER_RR_EN
  // Pointer survives flush; only a new grant moves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_rr_ptr <= w_winner;
    end
  end
`endif

  assign out_valid = r_valid;
  assign out_index = r_index;
  assign pending   = r_pend;

endmodule

// File: tb/tb_prio_event_arbiter.sv
// Bench for prio_event_arbiter: table-driven vectors on a WIDTH=8 instance plus
// hand sequences on WIDTH=5 and WIDTH=4 instances, checked through expectation queues.
module tb_prio_event_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req8;
  logic       flush8, rdy8, v8;
  logic [2:0] idx8;
  logic [7:0] pend8;

  logic [4:0] req5;
  logic       flush5, rdy5, v5;
  logic [2:0] idx5;
  logic [4:0] pend5;

  logic [3:0] req4;
  logic       flush4, rdy4, v4;
  logic [1:0] idx4;
  logic [3:0] pend4;

  prio_event_arbiter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .req(req8), .flush(flush8), .out_ready(rdy8),
    .out_valid(v8), .out_index(idx8), .pending(pend8)
  );
  prio_event_arbiter #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .req(req5), .flush(flush5), .out_ready(rdy5),
    .out_valid(v5), .out_index(idx5), .pending(pend5)
  );
  prio_event_arbiter #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .req(req4), .flush(flush4), .out_ready(rdy4),
    .out_valid(v4), .out_index(idx4), .pending(pend4)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       rdy;
    logic [7:0] req;
    logic       exp_v;
    logic [2:0] exp_idx;
    logic       chk_idx;
    logic [7:0] exp_pend;
  } vec_t;

  typedef struct {
    logic       exp_v;
    logic [2:0] exp_idx;
  } grant_t;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t   tbl [37];
  vec_t   exp_q [$];
  grant_t gnt_q [$];

  function automatic vec_t mk(input logic r, input logic f, input logic rd, input logic [7:0] rq,
                              input logic v, input logic [2:0] ix, input logic ci, input logic [7:0] p);
    vec_t t;
    t.rst = r; t.flush = f; t.rdy = rd; t.req = rq;
    t.exp_v = v; t.exp_idx = ix; t.chk_idx = ci; t.exp_pend = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    grant_t g;
    vec_t   e;
    int     k;

    //              rst fl rdy req    v  idx ci pend
    tbl[0]  = mk(1, 0, 1, 8'h00, 0, 0, 1, 8'h00);
    tbl[1]  = mk(0, 0, 1, 8'h00, 0, 0, 1, 8'h00);
    tbl[2]  = mk(0, 0, 1, 8'h00, 0, 0, 1, 8'h00);
    tbl[3]  = mk(0, 0, 1, 8'h00, 0, 0, 1, 8'h00);
    tbl[4]  = mk(0, 0, 1, 8'h00, 0, 0, 1, 8'h00);
    tbl[5]  = mk(0, 0, 1, 8'h00, 0, 0, 1, 8'h00);
    tbl[6]  = mk(0, 0, 1, 8'h24, 1, 5, 1, 8'h04);
    tbl[7]  = mk(0, 0, 1, 8'h00, 1, 2, 1, 8'h00);
    tbl[8]  = mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00);
    tbl[9]  = mk(0, 0, 0, 8'h02, 1, 1, 1, 8'h00);
    tbl[10] = mk(0, 0, 0, 8'h40, 1, 1, 1, 8'h40);
    tbl[11] = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h40);
    tbl[12] = mk(0, 0, 1, 8'h00, 1, 6, 1, 8'h00);
    tbl[13] = mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00);
    tbl[14] = mk(0, 0, 0, 8'h08, 1, 3, 1, 8'h00);
    tbl[15] = mk(0, 0, 1, 8'h08, 1, 3, 1, 8'h00);
    tbl[16] = mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00);
    tbl[17] = mk(0, 0, 0, 8'h30, 1, 5, 1, 8'h10);
    tbl[18] = mk(0, 1, 0, 8'hFF, 0, 0, 0, 8'h00);
    tbl[19] = mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00);
    tbl[20] = mk(0, 0, 0, 8'h80, 1, 7, 1, 8'h00);
    tbl[21] = mk(0, 0, 0, 8'h04, 1, 7, 1, 8'h04);
    tbl[22] = mk(0, 0, 0, 8'h04, 1, 7, 1, 8'h04);
    tbl[23] = mk(0, 0, 1, 8'h00, 1, 2, 1, 8'h00);
    tbl[24] = mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00);
    tbl[25] = mk(0, 0, 0, 8'h10, 1, 4, 1, 8'h00);
    tbl[26] = mk(0, 0, 0, 8'h10, 1, 4, 1, 8'h10);
    tbl[27] = mk(0, 0, 1, 8'h00, 1, 4, 1, 8'h00);
    tbl[28] = mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00);
    tbl[29] = mk(0, 0, 0, 8'h01, 1, 0, 1, 8'h00);
    tbl[30] = mk(0, 0, 0, 8'hF0, 1, 0, 1, 8'hF0);
    tbl[31] = mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
    tbl[32] = mk(0, 0, 1, 8'h00, 0, 0, 1, 8'h00);
    tbl[33] = mk(0, 0, 1, 8'h0E, 1, 3, 1, 8'h06);
    tbl[34] = mk(0, 0, 1, 8'h00, 1, 2, 1, 8'h02);
    tbl[35] = mk(0, 0, 1, 8'h00, 1, 1, 1, 8'h00);
    tbl[36] = mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00);

    rst = 1'b1;
    req8 = '0; flush8 = 1'b0; rdy8 = 1'b0;
    req5 = '0; flush5 = 1'b0; rdy5 = 1'b0;
    req4 = '0; flush4 = 1'b0; rdy4 = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 37; i++) begin
      rst = tbl[i].rst; flush8 = tbl[i].flush; rdy8 = tbl[i].rdy; req8 = tbl[i].req;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      $display("[TB] vec %0d rst=%b flush=%b ready=%b req=%h -> valid=%b idx=%0d pend=%h",
               i, e.rst, e.flush, e.rdy, e.req, v8, idx8, pend8);
      chk($sformatf("w8_valid[%0d]", i), 64'(v8), 64'(e.exp_v));
      chk($sformatf("w8_pending[%0d]", i), 64'(pend8), 64'(e.exp_pend));
      if (e.chk_idx) chk($sformatf("w8_index[%0d]", i), 64'(idx8), 64'(e.exp_idx));
    end
    rst = 1'b0; req8 = '0; flush8 = 1'b0; rdy8 = 1'b0;

    // WIDTH=5: two far-apart lines, never an index above 4.
    rdy5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req5 = (i == 0) ? 5'b10001 : 5'b00000;
      g.exp_v   = (i < 2);
      g.exp_idx = (i == 0) ? 3'd4 : 3'd0;
      gnt_q.push_back(g);
      @(posedge clk); #1;
      g = gnt_q.pop_front();
      $display("[TB] w5 cycle %0d req=%b -> valid=%b idx=%0d pend=%b", i, req5, v5, idx5, pend5);
      chk($sformatf("w5_valid[%0d]", i), 64'(v5), 64'(g.exp_v));
      if (g.exp_v) chk($sformatf("w5_index[%0d]", i), 64'(idx5), 64'(g.exp_idx));
      chk($sformatf("w5_range[%0d]", i), 64'(idx5 <= 3'd4), 64'(1));
    end
    req5 = '0; rdy5 = 1'b0;

    // WIDTH=4: all lines held for 8 cycles, then released and drained.
    rdy4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req4 = (i < 8) ? 4'hF : 4'h0;
      g.exp_v = (i < 11);
`ifdef PRIO_EVENT_ARBITER_RR_EN
      k = (i < 8) ? (3 - (i % 4)) : (3 - (i - 8));
`else
      k = (i < 8) ? 3 : (2 - (i - 8));
`endif
      g.exp_idx = 3'(k);
      gnt_q.push_back(g);
      @(posedge clk); #1;
      g = gnt_q.pop_front();
      $display("[TB] w4 cycle %0d req=%h -> valid=%b idx=%0d pend=%h", i, req4, v4, idx4, pend4);
      chk($sformatf("w4_valid[%0d]", i), 64'(v4), 64'(g.exp_v));
      if (g.exp_v) chk($sformatf("w4_index[%0d]", i), 64'(idx4), 64'(g.exp_idx));
    end
    req4 = '0; rdy4 = 1'b0;

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_event_arbiter.md
Name: prio_event_arbiter

Overview:
- Sequential successor to the combinational priority encoder, parametrised in request width.
- Captures single-cycle or level request pulses into a sticky pending register.
- Repeatedly selects one winner by priority and presents its index on a valid/ready output port, clearing that pending bit on grant.
- Sits between event sources (buttons, timers, message triggers) and the single consumer that services one event at a time.

Parameters:
- WIDTH, 64, number of request lines; any value >= 1, power of two not required.
- IDXW (localparam), ceil(log2(WIDTH)) with minimum 1, width of out_index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  WIDTH  request pulses; bit i high for one or more cycles sets pending bit i.
- flush  in  1  clears all pending bits and drops out_valid.
- out_ready  in  1  consumer accepts the current out_index.
- out_valid  out  1  out_index holds a granted event.
- out_index  out  IDXW  index of the granted request line.
- pending  out  WIDTH  current sticky pending register, not including the held grant.

Behaviour:
- Reset (rst high at clk edge): pend=0, out_valid=0, out_index=0, rr_ptr=0. Reset has priority over every other input, including mid-handshake; a held grant is discarded.
- cand = pend | req. The same-cycle request bypass gives 1-cycle latency from req to out_valid.
- Load condition: load = (~out_valid | out_ready) & (|cand) & ~flush.
- On load: out_valid<=1, out_index<=winner, and pend<=cand & ~onehot(winner).
- Not loading: pend<=cand. If out_valid & out_ready and cand==0, then out_valid<=0.
- out_index holds stable while out_valid & ~out_ready. No winner changes while the output is stalled.
- Back-to-back: with out_ready held high and several pending bits set, one grant is issued per cycle with no bubbles.
- Fixed priority (default): the highest set index wins, matching the encoder convention that the upper half has priority.
- flush: pend<=0 and out_valid<=0. Requests asserted in the same cycle as flush are dropped.
- A request on a bit that is already pending is merged and not counted twice.
- A request on the bit currently held in out_index sets pend again and produces a second grant later.
- Non-power-of-two WIDTH: unused index codes are never produced.
- WIDTH=1: out_index is always 0.
- pending output equals the pend register directly, with no bypass.

Optional Feature:
- Macro: PRIO_EVENT_ARBITER_RR_EN.
- Defined: round-robin mode.
  - rr_ptr (IDXW bits) updates to the winner on every load.
  - Search order is rr_ptr-1, rr_ptr-2, … 0, WIDTH-1, … rr_ptr (descending with wrap). The last-granted line therefore has the lowest priority.
  - rr_ptr=0 after reset, so the first grant matches fixed priority.
  - flush does not change rr_ptr.
- Undefined: fixed priority only. rr_ptr and its logic are absent.
- The port list is identical in both builds.

Test Plan:
- WIDTH=8: reset, then req=8'h00 for 5 cycles -> out_valid=0, out_index=0, pending=8'h00 throughout.
- req=8'b0010_0100 for 1 cycle, out_ready=1 -> cycle+1: out_valid=1, out_index=5; cycle+2: out_index=2; cycle+3: out_valid=0, pending=0.
- out_ready=0, req pulses on bit 1, then bit 6 -> out_index=1 stays held, pending=8'h40. Raise out_ready -> next grant is 6.
- Simultaneous events: out_valid with out_index=3 is accepted in the same cycle as req=8'h08 and flush=0 -> next cycle out_valid=1, out_index=3. Separately, flush with req=8'hFF -> next cycle out_valid=0, pending=0.
- rst asserted while out_valid=1 and pending=8'hF0 -> next cycle all outputs 0. WIDTH=5 build: req=5'b10001 -> grants 4 then 0, never an index >4.
- RR_EN build, WIDTH=4, req=4'hF held for 8 cycles with out_ready=1 -> grant sequence 3,2,1,0,3,2,1,0. Fixed build with the same stimulus -> 3,3,3,… every cycle.
